// File: rtl/tilt_pkg.sv
// Shared constants and helpers for the tilt-to-movement path: move-vector bit
// positions, accumulator width and the sign-magnitude to signed conversion.
package tilt_pkg;

   localparam int MOVE_RIGHT = 3;
   localparam int MOVE_LEFT  = 2;
   localparam int MOVE_DOWN  = 1;
   localparam int MOVE_UP    = 0;

   localparam int ACC_W = 12;

   // Bit 8 set means positive tilt; bits [7:0] carry the magnitude.
   function automatic logic signed [9:0] sm_to_s10(input logic [8:0] v);
      logic signed [9:0] m;
      m = signed'({2'b00, v[7:0]});
      return v[8] ? m : -m;
   endfunction

endpackage

// File: rtl/tilt_axis.sv
// One tilt axis: capture, optional 4-entry moving average (TILT_AVG_EN),
// dead zone and the tilt-proportional pulse accumulator.
module tilt_axis
   import tilt_pkg::*;
#(
   parameter int DEADZONE    = 16,
   parameter int STEP_THRESH = 256
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample,
   input  logic               tick,
   input  logic               enable,
   input  logic [8:0]         accel,
   output logic signed [9:0]  avg,
   output logic               pulse_pos,
   output logic               pulse_neg
);

   localparam logic [9:0]       DZ = 10'(DEADZONE);
   localparam logic [ACC_W-1:0] TH = ACC_W'(STEP_THRESH);

   logic signed [9:0]  avg_q, avg_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  cur;
   logic [9:0]         mag;
   logic               active;
   logic [ACC_W-1:0]   inc, base, sum;

`ifdef TILT_AVG_EN
   logic [3:0][9:0]    hist_q, hist_d;
   logic signed [11:0] sum4, avg_sh;

   function automatic logic signed [11:0] sx12(input logic [9:0] v);
      return signed'({{2{v[9]}}, v});
   endfunction
`endif

   assign cur    = sm_to_s10(accel);
   assign mag    = avg_q[9] ? 10'(-avg_q) : 10'(avg_q);
   assign active = enable && (mag >= DZ);
   assign inc    = ACC_W'(mag - DZ);

   always_comb begin
      avg_d     = avg_q;
      acc_d     = acc_q;
      sign_d    = sign_q;
      pulse_pos = 1'b0;
      pulse_neg = 1'b0;
      base      = '0;
      sum       = '0;
`ifdef TILT_AVG_EN
      hist_d = hist_q;
      sum4   = '0;
      avg_sh = '0;
      if (sample) begin
         hist_d = {hist_q[2:0], cur};
         sum4   = sx12(hist_d[0]) + sx12(hist_d[1]) + sx12(hist_d[2]) + sx12(hist_d[3]);
         avg_sh = sum4 >>> 2;
         avg_d  = avg_sh[9:0];
      end
`else
      if (sample) avg_d = cur;
`endif
      // Tick uses avg_q, i.e. the average registered before any same-cycle sample.
      if (!active) begin
         acc_d = '0;
      end else if (tick) begin
         // The stored sign tracks the last accumulation so a reversal restarts from zero.
         base   = (avg_q[9] != sign_q) ? '0 : acc_q;
         sum    = base + inc;
         sign_d = avg_q[9];
         if (sum >= TH) begin
            acc_d     = sum - TH;
            pulse_pos = ~avg_q[9];
            pulse_neg = avg_q[9];
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avg_q  <= '0;
         acc_q  <= '0;
         sign_q <= 1'b0;
`ifdef TILT_AVG_EN
         hist_q <= '0;
`endif
      end else begin
         avg_q  <= avg_d;
         acc_q  <= acc_d;
         sign_q <= sign_d;
`ifdef TILT_AVG_EN
         hist_q <= hist_d;
`endif
      end
   end

   assign avg = avg_q;

endmodule

// File: rtl/tilt_move_gen.sv
// Tilt to ball-movement pulse generator: sample/tick strobes, two axis
// channels and the registered move vector. Averaging is enabled by TILT_AVG_EN.
module tilt_move_gen
   import tilt_pkg::*;
#(
   parameter int SAMPLE_DIV  = 100000,
   parameter int TICK_DIV    = 1111111,
   parameter int DEADZONE    = 16,
   parameter int STEP_THRESH = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [8:0]        accel_x,
   input  logic [8:0]        accel_y,
   input  logic              enable,
   output logic [3:0]        move,
   output logic signed [9:0] tilt_x_avg,
   output logic signed [9:0] tilt_y_avg
);

   localparam int SCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [SCW-1:0] s_cnt_q, s_cnt_d;
   logic [TCW-1:0] t_cnt_q, t_cnt_d;
   logic [3:0]     move_q, move_d;
   logic           sample, tick;
   logic           x_pos, x_neg, y_pos, y_neg;

   assign sample = (s_cnt_q == SCW'(SAMPLE_DIV - 1));
   assign tick   = (t_cnt_q == TCW'(TICK_DIV - 1));

   always_comb begin
      s_cnt_d = sample ? '0 : s_cnt_q + 1'b1;
      t_cnt_d = tick   ? '0 : t_cnt_q + 1'b1;
      move_d  = '0;
      move_d[MOVE_RIGHT] = x_pos;
      move_d[MOVE_LEFT]  = x_neg;
      move_d[MOVE_UP]    = y_pos;
      move_d[MOVE_DOWN]  = y_neg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_cnt_q <= '0;
         t_cnt_q <= '0;
         move_q  <= '0;
      end else begin
         s_cnt_q <= s_cnt_d;
         t_cnt_q <= t_cnt_d;
         move_q  <= move_d;
      end
   end

   tilt_axis #(.DEADZONE(DEADZONE), .STEP_THRESH(STEP_THRESH)) u_x (
      .clk(clk), .reset(reset), .sample(sample), .tick(tick), .enable(enable),
      .accel(accel_x), .avg(tilt_x_avg), .pulse_pos(x_pos), .pulse_neg(x_neg)
   );

   tilt_axis #(.DEADZONE(DEADZONE), .STEP_THRESH(STEP_THRESH)) u_y (
      .clk(clk), .reset(reset), .sample(sample), .tick(tick), .enable(enable),
      .accel(accel_y), .avg(tilt_y_avg), .pulse_pos(y_pos), .pulse_neg(y_neg)
   );

   assign move = move_q;

endmodule

// File: tb/tb_tilt_move_gen.sv
// Directed bench for tilt_move_gen with SAMPLE_DIV=4, TICK_DIV=8; expected
// values differ between the averaged (TILT_AVG_EN) and direct builds.
module tb_tilt_move_gen;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [8:0]        accel_x = '0, accel_y = '0;
   logic              enable = 1'b1;
   logic [3:0]        move;
   logic signed [9:0] tilt_x_avg, tilt_y_avg;

   int errors = 0, checks = 0, overlap = 0;

   tilt_move_gen #(.SAMPLE_DIV(4), .TICK_DIV(8), .DEADZONE(16), .STEP_THRESH(256)) dut (
      .clk(clk), .reset(reset), .accel_x(accel_x), .accel_y(accel_y), .enable(enable),
      .move(move), .tilt_x_avg(tilt_x_avg), .tilt_y_avg(tilt_y_avg)
   );

   always #5 clk = ~clk;

`ifdef TILT_AVG_EN
   int ramp [5] = '{0, 36, 72, 108, 144};
   logic [8:0] pmask = 9'b1_0101_0000;
   localparam int REV_AT = 48, REV_FIRST = 32, REV_CNT = 1;
   localparam int DIAG_CNT = 8, RST_AT = 32, RST_FIRST = 28, RST_CNT = 1, RAMP1 = 36;
`else
   int ramp [5] = '{144, 144, 144, 144, 144};
   logic [8:0] pmask = 9'b1_0101_0100;
   localparam int REV_AT = 8, REV_FIRST = 16, REV_CNT = 2;
   localparam int DIAG_CNT = 9, RST_AT = 16, RST_FIRST = 12, RST_CNT = 2, RAMP1 = 144;
`endif

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [8:0] x, input logic [8:0] y, input logic en);
      reset   = 1'b1;
      accel_x = x;
      accel_y = y;
      enable  = en;
      step(2);
      reset   = 1'b0;
   endtask

   // Steps up to limit edges, recording first edge and count of move[idx].
   task automatic watch(input int idx, input int limit, output int first, output int cnt);
      first = 0;
      cnt   = 0;
      for (int n = 1; n <= limit; n++) begin
         step(1);
         if (move[3] && move[2]) overlap++;
         if (move[1] && move[0]) overlap++;
         if (move[idx]) begin
            cnt++;
            if (first == 0) first = n;
         end
      end
   endtask

   initial begin
      int first, cnt, bad, diff, wide, pulses;
      logic prev3;

      #2;
      chk("rst_move", int'(move), 0);
      chk("rst_xavg", int'(tilt_x_avg), 0);
      chk("rst_yavg", int'(tilt_y_avg), 0);

      // Ramp and steady rate, +144 on X.
      do_reset(9'h190, 9'h000, 1'b1);
      for (int n = 1; n <= 64; n++) begin
         step(1);
         if (n % 4 == 0) chk($sformatf("ramp_xavg_e%0d", n), int'(tilt_x_avg), ramp[(n / 4 > 4) ? 4 : n / 4]);
         if (n % 8 == 0) chk($sformatf("ramp_move_e%0d", n), int'(move), pmask[n / 8] ? 8 : 0);
         if (n % 8 == 1) chk($sformatf("ramp_width_e%0d", n), int'(move), 0);
      end
      chk("ramp_yavg", int'(tilt_y_avg), 0);

      // Dead zone, -10 on Y.
      do_reset(9'h000, 9'h00A, 1'b1);
      bad = 0;
      for (int n = 1; n <= 160; n++) begin
         step(1);
         if (move != 4'b0) bad++;
      end
      chk("dz_moves", bad, 0);
      chk("dz_yavg", int'(tilt_y_avg), -10);

      // Direction reversal +144 -> -144.
      do_reset(9'h190, 9'h000, 1'b1);
      step(REV_AT);
      accel_x = 9'h090;
      watch(2, 40, first, cnt);
      chk("rev_first_left", first, REV_FIRST);
      chk("rev_left_cnt", cnt, REV_CNT);
      chk("rev_xavg", int'(tilt_x_avg), -144);

      // Diagonal, +255 on both axes.
      do_reset(9'h1FF, 9'h1FF, 1'b1);
      diff = 0; wide = 0; pulses = 0; prev3 = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         step(1);
         if (move[3] != move[0]) diff++;
         if (move[2] || move[1]) diff++;
         if (move[3] && prev3) wide++;
         if (move[3]) pulses++;
         prev3 = move[3];
      end
      chk("diag_xy_match", diff, 0);
      chk("diag_width", wide, 0);
      chk("diag_pulses", pulses, DIAG_CNT);

      // Asynchronous reset while a pulse is on the output.
      do_reset(9'h190, 9'h000, 1'b1);
      step(RST_AT);
      chk("arst_pre_move", int'(move), 8);
      #2 reset = 1'b1;
      #1;
      chk("arst_move", int'(move), 0);
      chk("arst_xavg", int'(tilt_x_avg), 0);
      step(1);
      reset = 1'b0;
      step(4);
      chk("arst_ramp1", int'(tilt_x_avg), RAMP1);
      watch(3, 32, first, cnt);
      chk("arst_first", first, RST_FIRST);
      chk("arst_cnt", cnt, RST_CNT);

      // Enable low, then raised.
      do_reset(9'h1FF, 9'h000, 1'b0);
      watch(3, 40, first, cnt);
      chk("en_low_cnt", cnt, 0);
      chk("en_low_xavg", int'(tilt_x_avg), 255);
      enable = 1'b1;
      watch(3, 16, first, cnt);
      chk("en_first", first, 16);

      chk("opposite_overlap", overlap, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
